// File: rtl/fft_pkg.sv
// Shared definitions for the FFT write-back path: width defaults, FSM encoding
// and the complex-sample pair layout written back to sample memory.
package fft_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  // One complex sample is packed {re, im}; a butterfly result is two samples.
  typedef struct packed {
    logic signed [DATA_WIDTH_DEF-1:0] re;
    logic signed [DATA_WIDTH_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    cplx_t a;
    cplx_t b;
  } cplx_pair_t;

  localparam int CPLX_W      = $bits(cplx_t);
  localparam int CPLX_PAIR_W = $bits(cplx_pair_t);

endpackage

// File: rtl/fft_writeback_ctrl_if.sv
// Bus bundle between the address sequencer / butterfly pipeline (master side)
// and the write-back controller (slave side).
interface fft_writeback_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) ();

  // Handshake: every strobe here is valid-only with no back-pressure.
  // rd_issue, bf_valid and wr_en each qualify their payload for exactly the
  // cycle they are high; a payload is never held or retried by the receiver.
  logic                         rd_issue;
  logic [ADDR_WIDTH-1:0]        rd_addr_a;
  logic [ADDR_WIDTH-1:0]        rd_addr_b;
  logic                         bf_valid;
  logic signed [DATA_WIDTH-1:0] bf_a_re;
  logic signed [DATA_WIDTH-1:0] bf_a_im;
  logic signed [DATA_WIDTH-1:0] bf_b_re;
  logic signed [DATA_WIDTH-1:0] bf_b_im;
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr_a;
  logic [ADDR_WIDTH-1:0]        wr_addr_b;
  logic [2*DATA_WIDTH-1:0]      wr_data_a;
  logic [2*DATA_WIDTH-1:0]      wr_data_b;

  modport master (
    output rd_issue, rd_addr_a, rd_addr_b,
    output bf_valid, bf_a_re, bf_a_im, bf_b_re, bf_b_im,
    input  wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    input  rd_issue, rd_addr_a, rd_addr_b,
    input  bf_valid, bf_a_re, bf_a_im, bf_b_re, bf_b_im,
    output wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

endinterface

// File: rtl/fft_addr_fifo.sv
// Synchronous FIFO holding in-flight butterfly address pairs; extra pointer
// MSB distinguishes full from empty. clr has priority over push/pop.
module fft_addr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int IW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IW:0]      wr_ptr_q, wr_ptr_d;
  logic [IW:0]      rd_ptr_q, rd_ptr_d;

  // The caller only pushes on full when it pops in the same cycle, so the
  // slot being overwritten is the head that is read out this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[IW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) &&
                 (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fft_writeback_ctrl.sv
// FFT write-back controller: queues read-address pairs, writes butterfly
// results back in place and counts pairs per stage. Optional FFT_WB_SCALE_EN
// halves every component (round half up) before it is written.
module fft_writeback_ctrl
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stage_start,
  input  logic [ADDR_WIDTH-1:0]         pairs_per_stage,
  fft_writeback_ctrl_if.slave           bus,
  output logic                          busy,
  output logic                          stage_done,
  output logic [ADDR_WIDTH-1:0]         pair_count,
  output logic                          err_overflow,
  output logic                          err_underflow,
  output wb_state_e                     dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_fifo_level
);

  localparam int PAIR_AW = 2 * ADDR_WIDTH;
  localparam int DW2     = 2 * DATA_WIDTH;

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pps_q, pps_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_a_q, wr_addr_a_d;
  logic [ADDR_WIDTH-1:0] wr_addr_b_q, wr_addr_b_d;
  logic [DW2-1:0]        wr_data_a_q, wr_data_a_d;
  logic [DW2-1:0]        wr_data_b_q, wr_data_b_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PAIR_AW-1:0]    fifo_rdata;
  logic                  active, target_hit;
  logic [ADDR_WIDTH-1:0] cnt_inc;

  function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] x);
`ifdef FFT_WB_SCALE_EN
    // One guard bit keeps +max + 1 from wrapping before the arithmetic shift.
    logic signed [DATA_WIDTH:0] t;
    t = {x[DATA_WIDTH-1], x} + {{DATA_WIDTH{1'b0}}, 1'b1};
    scale = DATA_WIDTH'(t >>> 1);
`else
    scale = x;
`endif
  endfunction

  fft_addr_fifo #(
    .WIDTH (PAIR_AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stage_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({bus.rd_addr_a, bus.rd_addr_b}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (dbg_fifo_level)
  );

  // stage_start owns the cycle it arrives in: the FIFO is being cleared, so
  // no push, pop or error is recorded alongside it.
  always_comb begin
    active     = (state_q == ST_RUN) && !stage_start;
    target_hit = (cnt_q == pps_q);
    cnt_inc    = cnt_q + 1'b1;
    fifo_pop   = active && bus.bf_valid && !fifo_empty && !target_hit;
    fifo_push  = active && bus.rd_issue && (!fifo_full || fifo_pop);
  end

  always_comb begin
    state_d     = state_q;
    pps_d       = pps_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_a_d = wr_addr_a_q;
    wr_addr_b_d = wr_addr_b_q;
    wr_data_a_d = wr_data_a_q;
    wr_data_b_d = wr_data_b_q;
    ovf_d       = ovf_q | (active && bus.rd_issue && fifo_full && !fifo_pop);
    unf_d       = unf_q | (active && bus.bf_valid && fifo_empty);

    if (stage_start) begin
      state_d = ST_RUN;
      pps_d   = pairs_per_stage;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (fifo_pop) begin
            wr_en_d     = 1'b1;
            wr_addr_a_d = fifo_rdata[PAIR_AW-1:ADDR_WIDTH];
            wr_addr_b_d = fifo_rdata[ADDR_WIDTH-1:0];
            wr_data_a_d = {scale(bus.bf_a_re), scale(bus.bf_a_im)};
            wr_data_b_d = {scale(bus.bf_b_re), scale(bus.bf_b_im)};
            cnt_d       = cnt_inc;
            if (cnt_inc == pps_q) state_d = ST_DONE;
          end else if (target_hit) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pps_q       <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
      wr_data_a_q <= '0;
      wr_data_b_q <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pps_q       <= pps_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_addr_b_q <= wr_addr_b_d;
      wr_data_a_q <= wr_data_a_d;
      wr_data_b_q <= wr_data_b_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr_a  = wr_addr_a_q;
  assign bus.wr_addr_b  = wr_addr_b_q;
  assign bus.wr_data_a  = wr_data_a_q;
  assign bus.wr_data_b  = wr_data_b_q;
  assign busy           = (state_q != ST_IDLE);
  assign stage_done     = (state_q == ST_DONE);
  assign pair_count     = cnt_q;
  assign err_overflow   = ovf_q;
  assign err_underflow  = unf_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fft_writeback_ctrl.sv
// Directed bench for fft_writeback_ctrl: expected writes go into a scoreboard
// queue, a negedge monitor pops and compares every wr_en strobe.
`timescale 1ns/1ps
module tb_fft_writeback_ctrl;
  import fft_pkg::*;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int EW = 2*AW + 4*DW;

`ifdef FFT_WB_SCALE_EN
  localparam logic [DW-1:0] E_AR = 16'd50;
  localparam logic [DW-1:0] E_AI = -16'sd50;
  localparam logic [DW-1:0] E_BR = 16'd4;
  localparam logic [DW-1:0] E_BI = -16'sd3;
  localparam logic [DW-1:0] S_AR = 16'd16384;
  localparam logic [DW-1:0] S_AI = -16'sd1;
  localparam logic [DW-1:0] S_BR = -16'sd16384;
  localparam logic [DW-1:0] S_BI = 16'd0;
`else
  localparam logic [DW-1:0] E_AR = 16'd100;
  localparam logic [DW-1:0] E_AI = -16'sd100;
  localparam logic [DW-1:0] E_BR = 16'd7;
  localparam logic [DW-1:0] E_BI = -16'sd7;
  localparam logic [DW-1:0] S_AR = 16'd32767;
  localparam logic [DW-1:0] S_AI = -16'sd3;
  localparam logic [DW-1:0] S_BR = -16'sd32768;
  localparam logic [DW-1:0] S_BI = -16'sd1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            stage_start;
  logic [AW-1:0]   pairs_per_stage;
  logic            busy, stage_done, err_overflow, err_underflow;
  logic [AW-1:0]   pair_count;
  wb_state_e       dbg_state;
  logic [3:0]      dbg_fifo_level;

  fft_writeback_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fft_writeback_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stage_start     (stage_start),
    .pairs_per_stage (pairs_per_stage),
    .bus             (bus),
    .busy            (busy),
    .stage_done      (stage_done),
    .pair_count      (pair_count),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow),
    .dbg_state       (dbg_state),
    .dbg_fifo_level  (dbg_fifo_level)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [EW-1:0] exp_q[$];

  function automatic logic [EW-1:0] mk(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                       input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                                       input logic [DW-1:0] br, input logic [DW-1:0] bi);
    return {a, b, ar, ai, br, bi};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] got, e;
    if (rst_n) begin
      if (stage_done) done_cnt++;
      if (bus.wr_en) begin
        got = {bus.wr_addr_a, bus.wr_addr_b, bus.wr_data_a, bus.wr_data_b};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %h required no write", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL write_pair: got %h required %h", got, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_stage(input logic [AW-1:0] n);
    stage_start     = 1'b1;
    pairs_per_stage = n;
    tick();
    stage_start     = 1'b0;
  endtask

  task automatic set_bf(input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                        input logic [DW-1:0] br, input logic [DW-1:0] bi);
    bus.bf_a_re = ar;
    bus.bf_a_im = ai;
    bus.bf_b_re = br;
    bus.bf_b_im = bi;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int d0;
    stage_start     = 1'b0;
    pairs_per_stage = '0;
    bus.rd_issue    = 1'b0;
    bus.rd_addr_a   = '0;
    bus.rd_addr_b   = '0;
    bus.bf_valid    = 1'b0;
    set_bf(16'sd100, -16'sd100, 16'sd7, -16'sd7);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", 64'(bus.wr_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_stage_done", 64'(stage_done), 64'(0));
    check("rst_pair_count", 64'(pair_count), 64'(0));
    check("rst_errs", 64'({err_overflow, err_underflow}), 64'(0));
    check("rst_level", 64'(dbg_fifo_level), 64'(0));
    rst_n = 1'b1;
    tick();

    // basic flow: bf_valid three cycles after each push
    start_stage(12'd4);
    for (int c = 0; c < 7; c++) begin
      bus.rd_issue  = (c < 4);
      bus.rd_addr_a = AW'(2*c);
      bus.rd_addr_b = AW'(2*c + 1);
      bus.bf_valid  = (c >= 3);
      if (c >= 3) exp_q.push_back(mk(AW'(2*(c-3)), AW'(2*(c-3)+1), E_AR, E_AI, E_BR, E_BI));
      tick();
    end
    bus.rd_issue = 1'b0;
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("basic_stage_done", 64'(stage_done), 64'(1));
    check("basic_pair_count", 64'(pair_count), 64'(4));
    check("basic_busy_done", 64'(busy), 64'(1));
    tick();
    @(negedge clk);
    check("basic_busy_idle", 64'(busy), 64'(0));
    check("basic_done_pulses", 64'(done_cnt), 64'(1));
    check("basic_addr_hold", 64'({bus.wr_en, bus.wr_addr_a}), 64'({1'b0, 12'd6}));
    check("basic_sb_empty", 64'(exp_q.size()), 64'(0));
    check("basic_no_errs", 64'({err_overflow, err_underflow}), 64'(0));

    // full pipeline and overflow
    start_stage(12'd20);
    for (int i = 0; i < 8; i++) begin
      bus.rd_issue  = 1'b1;
      bus.rd_addr_a = AW'(12'h100 + i);
      bus.rd_addr_b = AW'(12'h200 + i);
      tick();
    end
    bus.rd_issue = 1'b0;
    @(negedge clk);
    check("full_level8", 64'(dbg_fifo_level), 64'(8));
    check("full_no_ovf", 64'(err_overflow), 64'(0));
    bus.rd_issue  = 1'b1;
    bus.rd_addr_a = 12'h108;
    bus.rd_addr_b = 12'h208;
    bus.bf_valid  = 1'b1;
    exp_q.push_back(mk(12'h100, 12'h200, E_AR, E_AI, E_BR, E_BI));
    tick();
    bus.rd_issue = 1'b0;
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("full_pushpop_level", 64'(dbg_fifo_level), 64'(8));
    check("full_pushpop_no_ovf", 64'(err_overflow), 64'(0));
    bus.rd_issue  = 1'b1;
    bus.rd_addr_a = 12'h109;
    bus.rd_addr_b = 12'h209;
    tick();
    bus.rd_issue = 1'b0;
    @(negedge clk);
    check("ovf_set", 64'(err_overflow), 64'(1));
    check("ovf_level", 64'(dbg_fifo_level), 64'(8));
    for (int i = 0; i < 8; i++) begin
      bus.bf_valid = 1'b1;
      exp_q.push_back(mk(AW'(12'h101 + i), AW'(12'h201 + i), E_AR, E_AI, E_BR, E_BI));
      tick();
    end
    bus.bf_valid = 1'b0;
    tick();
    @(negedge clk);
    check("drain_level0", 64'(dbg_fifo_level), 64'(0));
    check("drain_sb_empty", 64'(exp_q.size()), 64'(0));
    check("drain_pair_count", 64'(pair_count), 64'(9));

    // underflow: bf_valid on empty FIFO
    check("pre_unf_clear", 64'(err_underflow), 64'(0));
    bus.bf_valid = 1'b1;
    tick();
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("unf_set", 64'(err_underflow), 64'(1));
    check("unf_pair_count", 64'(pair_count), 64'(9));
    start_stage(12'd2);
    @(negedge clk);
    check("sticky_errs", 64'({err_overflow, err_underflow}), 64'(2'b11));
    check("restart_level0", 64'(dbg_fifo_level), 64'(0));

    // restart mid-stage
    start_stage(12'd4);
    for (int i = 0; i < 4; i++) begin
      bus.rd_issue  = 1'b1;
      bus.rd_addr_a = AW'(12'h300 + i);
      bus.rd_addr_b = AW'(12'h380 + i);
      tick();
    end
    bus.rd_issue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bf_valid = 1'b1;
      exp_q.push_back(mk(AW'(12'h300 + i), AW'(12'h380 + i), E_AR, E_AI, E_BR, E_BI));
      tick();
    end
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("mid_pair_count2", 64'(pair_count), 64'(2));
    d0 = done_cnt;
    start_stage(12'd2);
    @(negedge clk);
    check("mid_restart_count0", 64'(pair_count), 64'(0));
    check("mid_restart_level0", 64'(dbg_fifo_level), 64'(0));
    for (int i = 0; i < 2; i++) begin
      bus.rd_issue  = 1'b1;
      bus.rd_addr_a = AW'(12'h3a0 + i);
      bus.rd_addr_b = AW'(12'h3b0 + i);
      tick();
    end
    bus.rd_issue = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.bf_valid = 1'b1;
      exp_q.push_back(mk(AW'(12'h3a0 + i), AW'(12'h3b0 + i), E_AR, E_AI, E_BR, E_BI));
      tick();
    end
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("mid_stage_done", 64'(stage_done), 64'(1));
    check("mid_pair_count_final", 64'(pair_count), 64'(2));
    tick();
    check("mid_done_once", 64'(done_cnt - d0), 64'(1));
    check("mid_sb_empty", 64'(exp_q.size()), 64'(0));

    // scaling boundary values
    start_stage(12'd1);
    bus.rd_issue  = 1'b1;
    bus.rd_addr_a = 12'h0aa;
    bus.rd_addr_b = 12'h0bb;
    tick();
    bus.rd_issue = 1'b0;
    set_bf(16'sd32767, -16'sd3, -16'sd32768, -16'sd1);
    bus.bf_valid = 1'b1;
    exp_q.push_back(mk(12'h0aa, 12'h0bb, S_AR, S_AI, S_BR, S_BI));
    tick();
    bus.bf_valid = 1'b0;
    set_bf(16'sd100, -16'sd100, 16'sd7, -16'sd7);
    @(negedge clk);
    check("scale_stage_done", 64'(stage_done), 64'(1));
    tick();
    check("scale_sb_empty", 64'(exp_q.size()), 64'(0));

    // zero pairs per stage
    start_stage(12'd0);
    @(negedge clk);
    check("zero_busy", 64'({busy, stage_done}), 64'(2'b10));
    tick();
    @(negedge clk);
    check("zero_stage_done", 64'(stage_done), 64'(1));
    check("zero_pair_count", 64'(pair_count), 64'(0));
    tick();
    @(negedge clk);
    check("zero_idle", 64'(busy), 64'(0));

    // async reset mid-stage with three entries queued
    start_stage(12'd8);
    for (int i = 0; i < 3; i++) begin
      bus.rd_issue  = 1'b1;
      bus.rd_addr_a = AW'(12'h500 + i);
      bus.rd_addr_b = AW'(12'h600 + i);
      tick();
    end
    bus.rd_issue = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl", 64'({bus.wr_en, busy, stage_done, err_overflow, err_underflow}), 64'(0));
    check("arst_pair_count", 64'(pair_count), 64'(0));
    check("arst_wr_addr", 64'({bus.wr_addr_a, bus.wr_addr_b}), 64'(0));
    check("arst_wr_data", 64'({bus.wr_data_a, bus.wr_data_b}), 64'(0));
    check("arst_level", 64'(dbg_fifo_level), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.bf_valid = 1'b1;
    tick();
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("arst_idle_bf_ignored", 64'(err_underflow), 64'(0));
    start_stage(12'd2);
    bus.bf_valid = 1'b1;
    tick();
    bus.bf_valid = 1'b0;
    @(negedge clk);
    check("arst_entries_lost", 64'(err_underflow), 64'(1));
    tick();
    check("final_sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
